// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-subset main control FSM with ALU decode
// Optional addi support is enabled by defining MC_CTRL_ADDI_EN.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALUcontrol,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
`ifdef MC_CTRL_ADDI_EN
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       fn_legal;
    logic [3:0] fn_alu;
    logic       pc_write;
    logic       pc_write_cond;

    always_comb begin
        fn_legal = 1'b1;
        fn_alu   = ALU_ADD;
        case (funct)
            6'h20:   fn_alu = ALU_ADD;
            6'h22:   fn_alu = ALU_SUB;
            6'h24:   fn_alu = ALU_AND;
            6'h25:   fn_alu = ALU_OR;
            6'h2A:   fn_alu = ALU_SLT;
            default: fn_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        PCSource      = 2'b00;
        ALUcontrol    = ALU_ADD;
        illegal_op    = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = 2'b01;
                IRWrite  = mem_ready;
                pc_write = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:       state_d = S_ADDIEX;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUcontrol = fn_alu;
                illegal_op = ~fn_legal;
                state_d    = fn_legal ? S_ALUWB : S_FETCH;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUcontrol    = ALU_SUB;
                pc_write_cond = 1'b1;
                PCSource      = 2'b01;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
`endif
            default: begin
                // Unused encodings recover to FETCH with every control line low.
                ALUcontrol = 4'b0000;
                state_d    = S_FETCH;
            end
        endcase

        pc_en = pc_write | (pc_write_cond & zero);

        // Reset masks every strobe so an aborted instruction cannot write anything.
        if (reset) begin
            pc_en      = 1'b0;
            IorD       = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            MemtoReg   = 1'b0;
            RegDst     = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            PCSource   = 2'b00;
            ALUcontrol = ALU_ADD;
            illegal_op = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUcontrol;
    logic       illegal_op;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;
    bit mr_script[$];

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUcontrol(ALUcontrol), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] observed();
        return {pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                ALUSrcA, ALUSrcB, PCSource, ALUcontrol, illegal_op};
    endfunction

    function automatic bit funct_ok(logic [5:0] f);
        return f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A;
    endfunction

    function automatic logic [3:0] alu_of(logic [5:0] f);
        if (f == 6'h22) return 4'b0110;
        if (f == 6'h24) return 4'b0000;
        if (f == 6'h25) return 4'b0001;
        if (f == 6'h2A) return 4'b0111;
        return 4'b0010;
    endfunction

    function automatic bit addi_on();
`ifdef MC_CTRL_ADDI_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit opcode_ok(logic [5:0] op);
        return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02 ||
               (op == 6'h08 && addi_on());
    endfunction

    // Expected control word built field by field from the per-step rules.
    function automatic logic [17:0] expect_ctrl(int s, bit mr, bit z, logic [5:0] op, logic [5:0] f);
        bit pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, pcs;
        logic [3:0] alu;
        bit ill;
        pcw  = (s == 0 && mr) || s == 9;
        pcwc = (s == 8);
        iord = (s == 3 || s == 5);
        mrd  = (s == 0 || s == 3);
        mwr  = (s == 5);
        irw  = (s == 0 && mr);
        m2r  = (s == 4);
        rdst = (s == 7);
        rw   = (s == 4 || s == 7 || s == 11);
        srca = (s == 2 || s == 6 || s == 8 || s == 10);
        srcb = (s == 0) ? 2'b01 : (s == 1) ? 2'b11 : (s == 2 || s == 10) ? 2'b10 : 2'b00;
        pcs  = (s == 8) ? 2'b01 : (s == 9) ? 2'b10 : 2'b00;
        alu  = (s == 6) ? alu_of(f) : (s == 8) ? 4'b0110 : 4'b0010;
        ill  = (s == 1 && !opcode_ok(op)) || (s == 6 && !funct_ok(f));
        return {pcw | (pcwc & z), iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, pcs, alu, ill};
    endfunction

    // Runs one instruction starting just after a rising edge with the FSM in FETCH.
    task automatic run_instr(string name, logic [5:0] op, logic [5:0] f, bit z, int stall_pct);
        int plan[$];
        int idx = 0;
        int cyc = 0;
        bit mr;
        case (op)
            6'h00: plan = funct_ok(f) ? '{0, 1, 6, 7} : '{0, 1, 6};
            6'h23: plan = '{0, 1, 2, 3, 4};
            6'h2B: plan = '{0, 1, 2, 5};
            6'h04: plan = '{0, 1, 8};
            6'h02: plan = '{0, 1, 9};
            6'h08: plan = addi_on() ? '{0, 1, 10, 11} : '{0, 1};
            default: plan = '{0, 1};
        endcase
        opcode = op;
        funct  = f;
        zero   = z;
        while (idx < plan.size()) begin
            if (mr_script.size() > 0) mr = mr_script.pop_front();
            else mr = ($urandom_range(99) >= stall_pct);
            mem_ready = mr;
            @(negedge clk);
            checks++;
            if (state !== plan[idx][3:0]) begin
                errors++;
                $display("FAIL %s state cyc=%0d got=%0d exp=%0d", name, cyc, state, plan[idx]);
            end
            checks++;
            if (observed() !== expect_ctrl(plan[idx], mr, z, op, f)) begin
                errors++;
                $display("FAIL %s ctrl cyc=%0d state=%0d got=%b exp=%b", name, cyc, plan[idx],
                         observed(), expect_ctrl(plan[idx], mr, z, op, f));
            end
            @(posedge clk);
            #1;
            if (!((plan[idx] == 0 || plan[idx] == 3 || plan[idx] == 5) && !mr)) idx++;
            cyc++;
            if (cyc > 64) begin
                errors++;
                $display("FAIL %s cycle budget exceeded got=%0d exp<=64", name, cyc);
                break;
            end
        end
        mr_script.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'h3F; funct = 6'h00; zero = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if (observed() !== 18'b000000000_00_00_0010_0) begin
                errors++;
                $display("FAIL reset_outputs got=%b exp=%b", observed(), 18'b000000000_00_00_0010_0);
            end
            checks++;
            if (state !== 4'd0) begin
                errors++;
                $display("FAIL reset_state got=%0d exp=0", state);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (observed() !== 18'b101010000_01_00_0010_0 || state !== 4'd0) begin
            errors++;
            $display("FAIL first_fetch got=%b/%0d exp=%b/0", observed(), state, 18'b101010000_01_00_0010_0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (illegal_op !== 1'b1 || state !== 4'd1) begin
            errors++;
            $display("FAIL decode_illegal got=%b/%0d exp=1/1", illegal_op, state);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        run_instr("rtype_sub", 6'h00, 6'h22, 1'b0, 0);
        run_instr("rtype_slt", 6'h00, 6'h2A, 1'b1, 0);
    endtask

    task automatic test_lw_stall();
        mr_script = '{1, 1, 1, 0, 0, 0, 1, 1};
        run_instr("lw_stall", 6'h23, 6'h00, 1'b0, 0);
    endtask

    task automatic test_beq();
        run_instr("beq_taken", 6'h04, 6'h00, 1'b1, 0);
        run_instr("beq_not_taken", 6'h04, 6'h00, 1'b0, 0);
    endtask

    task automatic test_addi();
        run_instr("addi", 6'h08, 6'h00, 1'b0, 0);
    endtask

    task automatic test_reset_in_memwr();
        opcode = 6'h2B; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 4'd5 || MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL memwr_entry got=%0d/%b exp=5/1", state, MemWrite);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (MemWrite !== 1'b0 || RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL memwr_reset_strobe got=%b%b exp=00", MemWrite, RegWrite);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 4'd0 || MemWrite !== 1'b0 || IRWrite !== 1'b0) begin
            errors++;
            $display("FAIL memwr_after_reset got=%0d/%b/%b exp=0/0/0", state, MemWrite, IRWrite);
        end
        @(posedge clk); #1;
        run_instr("bad_funct", 6'h00, 6'h3F, 1'b0, 0);
    endtask

    task automatic test_random();
        logic [5:0] ops[7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h00};
        logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        for (int n = 0; n < 200; n++) begin
            logic [5:0] op, f;
            op = ops[$urandom_range(6)];
            if ($urandom_range(9) == 0) op = 6'($urandom);
            f = ($urandom_range(4) == 0) ? 6'($urandom) : fns[$urandom_range(4)];
            run_instr("random", op, f, 1'($urandom), 30);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_beq();
        test_addi();
        test_reset_in_memwr();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
